// File: rtl/fmc_i2c_txn_sequencer.sv
// =============================================================================
// fmc_i2c_txn_sequencer : two-requester round-robin I2C register txn sequencer.
// Optional watchdog with FMC_I2C_TIMEOUT_EN. Rev 1.0
// =============================================================================
`default_nettype none

module fmc_i2c_txn_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_rw,
    input  logic [6:0] req0_dev,
    input  logic [7:0] req0_reg,
    input  logic [7:0] req0_wdata,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_rw,
    input  logic [6:0] req1_dev,
    input  logic [7:0] req1_reg,
    input  logic [7:0] req1_wdata,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_op,
    output logic [7:0] cmd_wdata,
    input  logic       done_valid,
    input  logic       done_nack,
    input  logic [7:0] done_rdata,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       rsp_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] OP_START  = 3'd0;
    localparam logic [2:0] OP_WRITE  = 3'd1;
    localparam logic [2:0] OP_READ   = 3'd2;
    localparam logic [2:0] OP_STOP   = 3'd3;
    localparam logic [2:0] OP_RSTART = 3'd4;

    state_t     state, state_nxt;
    logic [2:0] idx;
    logic       rw, id, last_grant, nack, tout;
    logic [6:0] dev;
    logic [7:0] regad, wdata, rdata;

    logic       grant, accept, done, tmo;
    logic [2:0] op;
    logic [7:0] op_byte;
    logic [2:0] stop_idx;

    // Tie-break favours the requester that was not served last.
    assign grant      = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = rst_n & (state == S_IDLE) & req0_valid & ~grant;
    assign req1_ready = rst_n & (state == S_IDLE) & req1_valid & grant;
    assign accept     = req0_ready | req1_ready;
    assign done       = (state == S_WAIT) & done_valid;
    assign stop_idx   = rw ? 3'd6 : 3'd4;

    always_comb begin
        op      = OP_STOP;
        op_byte = 8'h00;
        case (idx)
            3'd0: op = OP_START;
            3'd1: begin op = OP_WRITE; op_byte = {dev, 1'b0}; end
            3'd2: begin op = OP_WRITE; op_byte = regad; end
            3'd3: begin
                if (rw) begin
                    op = OP_RSTART;
                end else begin
                    op      = OP_WRITE;
                    op_byte = wdata;
                end
            end
            3'd4: begin
                if (rw) begin
                    op      = OP_WRITE;
                    op_byte = {dev, 1'b1};
                end
            end
            3'd5: op = OP_READ;
            default: op = OP_STOP;
        endcase
    end

`ifdef FMC_I2C_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (cmd_valid & cmd_ready) begin
            wd_cnt <= '0;
        end else if (state == S_WAIT) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // A done arriving on the expiry cycle still wins over the watchdog.
    assign tmo = (state == S_WAIT) & ~done_valid & (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_valid   = 1'b0;
        cmd_op      = 3'd0;
        cmd_wdata   = 8'h00;
        rsp_valid   = 1'b0;
        rsp_id      = 1'b0;
        rsp_rdata   = 8'h00;
        rsp_nack    = 1'b0;
        rsp_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                cmd_valid = 1'b1;
                cmd_op    = op;
                cmd_wdata = op_byte;
                if (cmd_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (tmo) begin
                    state_nxt = S_RESP;
                end else if (done_valid) begin
                    state_nxt = (op == OP_STOP) ? S_RESP : S_ISSUE;
                end
            end
            default: begin
                rsp_valid   = 1'b1;
                rsp_id      = id;
                rsp_rdata   = (nack | tout) ? 8'h00 : rdata;
                rsp_nack    = nack;
                rsp_timeout = tout;
                state_nxt   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= 3'd0;
            rw         <= 1'b0;
            id         <= 1'b0;
            last_grant <= 1'b1;
            nack       <= 1'b0;
            tout       <= 1'b0;
            dev        <= 7'h00;
            regad      <= 8'h00;
            wdata      <= 8'h00;
            rdata      <= 8'h00;
        end else if (accept) begin
            idx        <= 3'd0;
            rw         <= grant ? req1_rw    : req0_rw;
            dev        <= grant ? req1_dev   : req0_dev;
            regad      <= grant ? req1_reg   : req0_reg;
            wdata      <= grant ? req1_wdata : req0_wdata;
            id         <= grant;
            last_grant <= grant;
            nack       <= 1'b0;
            tout       <= 1'b0;
            rdata      <= 8'h00;
        end else if (tmo) begin
            tout <= 1'b1;
        end else if (done) begin
            if (op == OP_READ) rdata <= done_rdata;
            if ((op == OP_WRITE) && done_nack) begin
                nack <= 1'b1;
                idx  <= stop_idx;
            end else if (op != OP_STOP) begin
                idx <= idx + 3'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fmc_i2c_txn_sequencer.sv
// =============================================================================
// tb_fmc_i2c_txn_sequencer : directed self-checking bench with a behavioural
// byte engine. Rev 1.0
// =============================================================================
`default_nettype none

module tb_fmc_i2c_txn_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid, req0_ready, req0_rw;
    logic [6:0] req0_dev;
    logic [7:0] req0_reg, req0_wdata;
    logic       req1_valid, req1_ready, req1_rw;
    logic [6:0] req1_dev;
    logic [7:0] req1_reg, req1_wdata;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_wdata;
    logic       done_valid, done_nack;
    logic [7:0] done_rdata;
    logic       rsp_valid, rsp_id, rsp_nack, rsp_timeout;
    logic [7:0] rsp_rdata;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s", tag);
        end
    endtask

    fmc_i2c_txn_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rw(req0_rw),
        .req0_dev(req0_dev), .req0_reg(req0_reg), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rw(req1_rw),
        .req1_dev(req1_dev), .req1_reg(req1_reg), .req1_wdata(req1_wdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
        .done_valid(done_valid), .done_nack(done_nack), .done_rdata(done_rdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
        .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    // Engine model: sees a handshake mid-cycle, answers with done in the next cycle.
    logic [7:0] rd_val = 8'h00;
    int         nack_at = -1;
    int         hold_at = -1;
    bit         withhold = 1'b0;
    bit         force_done = 1'b0;
    logic [2:0] log_op [0:127];
    logic [7:0] log_wd [0:127];
    int         log_n = 0;

    initial begin
        bit         hs;
        logic [2:0] op;
        int         ix;
        done_valid = 1'b0;
        done_nack  = 1'b0;
        done_rdata = 8'h00;
        forever begin
            @(negedge clk);
            hs = cmd_valid && cmd_ready;
            op = cmd_op;
            ix = log_n;
            if (hs && log_n < 128) begin
                log_op[log_n] = cmd_op;
                log_wd[log_n] = cmd_wdata;
                log_n++;
            end
            @(posedge clk);
            #1;
            done_valid = (hs && !withhold && ix != hold_at) || force_done;
            done_nack  = hs && op == 3'd1 && ix == nack_at;
            done_rdata = (hs && op == 3'd2) ? rd_val : 8'h5A;
        end
    end

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit id, input bit rw, input logic [6:0] dev,
                        input logic [7:0] rg, input logic [7:0] wd);
        drive_pt();
        if (id) begin
            req1_rw = rw; req1_dev = dev; req1_reg = rg; req1_wdata = wd; req1_valid = 1'b1;
        end else begin
            req0_rw = rw; req0_dev = dev; req0_reg = rg; req0_wdata = wd; req0_valid = 1'b1;
        end
        @(negedge clk);
        chk("accept_ready", (id ? req1_ready : req0_ready) === 1'b1);
        drive_pt();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_rsp(input int n0, output int n);
        n = n0;
        while (!rsp_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_arrived", rsp_valid === 1'b1);
    endtask

    task automatic chk_log(input int base, input int cnt, input logic [20:0] ops,
                           input logic [55:0] wds);
        chk("log_count", (log_n - base) === cnt);
        for (int i = 0; i < cnt; i++) begin
            chk("log_op", log_op[base + i] === ops[3*i +: 3]);
            chk("log_wdata", log_wd[base + i] === wds[8*i +: 8]);
        end
    endtask

    initial begin
        int n;
        int base;
        int extra;
        req0_valid = 1'b1; req0_rw = 1'b0; req0_dev = 7'h00; req0_reg = 8'h00; req0_wdata = 8'h00;
        req1_valid = 1'b0; req1_rw = 1'b0; req1_dev = 7'h00; req1_reg = 8'h00; req1_wdata = 8'h00;
        cmd_ready  = 1'b1;

        // Reset state, with a pending request that must not see ready.
        repeat (3) @(negedge clk);
        chk("rst_req0_ready", req0_ready === 1'b0);
        chk("rst_cmd_valid", cmd_valid === 1'b0);
        chk("rst_cmd_op", cmd_op === 3'd0);
        chk("rst_cmd_wdata", cmd_wdata === 8'h00);
        chk("rst_rsp_valid", rsp_valid === 1'b0);
        chk("rst_rsp_rdata", rsp_rdata === 8'h00);
        chk("rst_rsp_flags", {rsp_id, rsp_nack, rsp_timeout} === 3'b000);
        req0_valid = 1'b0;
        drive_pt();
        rst_n = 1'b1;
        @(negedge clk);

        // Req0 write: minimum 12-cycle transaction.
        base = log_n;
        send(1'b0, 1'b0, 7'h3E, 8'h00, 8'h01);
        chk("t1_start_valid", cmd_valid === 1'b1);
        chk("t1_start_op", cmd_op === 3'd0);
        wait_rsp(1, n);
        chk("t1_latency", n === 11);
        chk("t1_rsp_id", rsp_id === 1'b0);
        chk("t1_rsp_nack", rsp_nack === 1'b0);
        chk("t1_rsp_rdata", rsp_rdata === 8'h00);
        chk_log(base, 5, {3'd3, 3'd1, 3'd1, 3'd1, 3'd0}, {8'h00, 8'h01, 8'h00, 8'h7C, 8'h00});
        @(negedge clk);
        chk("t1_rsp_single", rsp_valid === 1'b0);

        // Req1 read returning 0xA5.
        rd_val = 8'hA5;
        base = log_n;
        send(1'b1, 1'b1, 7'h70, 8'h2D, 8'hFF);
        wait_rsp(1, n);
        chk("t2_latency", n === 15);
        chk("t2_rsp_id", rsp_id === 1'b1);
        chk("t2_rsp_rdata", rsp_rdata === 8'hA5);
        chk("t2_rsp_nack", rsp_nack === 1'b0);
        chk_log(base, 7, {3'd3, 3'd2, 3'd1, 3'd4, 3'd1, 3'd1, 3'd0},
                {8'h00, 8'h00, 8'hE1, 8'h00, 8'h2D, 8'hE0, 8'h00});

        // Engine backpressure holds the START command stable.
        cmd_ready = 1'b0;
        send(1'b0, 1'b0, 7'h01, 8'h02, 8'h03);
        repeat (2) @(negedge clk);
        chk("bp_hold_valid", cmd_valid === 1'b1);
        chk("bp_hold_op", cmd_op === 3'd0);
        drive_pt();
        cmd_ready = 1'b1;
        @(negedge clk);
        wait_rsp(4, n);
        chk("bp_latency", n === 14);

        // Reset asserted while a read sits in WAIT.
        withhold = 1'b1;
        send(1'b0, 1'b1, 7'h11, 8'h22, 8'h00);
        repeat (3) @(negedge clk);
        chk("t6_waiting", cmd_valid === 1'b0);
        req1_valid = 1'b1;
        #1;
        chk("t6_busy_ready", req1_ready === 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_cmd", {cmd_valid, cmd_op, cmd_wdata} === 12'h000);
        chk("t6_rst_rsp", {rsp_valid, rsp_id, rsp_nack, rsp_timeout, rsp_rdata} === 12'h000);
        chk("t6_rst_ready", req1_ready === 1'b0);
        @(negedge clk);
        chk("t6_no_rsp", rsp_valid === 1'b0);
        withhold = 1'b0;
        req1_valid = 1'b0;
        drive_pt();
        rst_n = 1'b1;
        @(negedge clk);
        base = log_n;
        send(1'b0, 1'b0, 7'h12, 8'h34, 8'h56);
        chk("t6_restart_op", cmd_op === 3'd0);
        wait_rsp(1, n);
        chk("t6_latency", n === 11);
        chk_log(base, 5, {3'd3, 3'd1, 3'd1, 3'd1, 3'd0}, {8'h00, 8'h56, 8'h34, 8'h24, 8'h00});

        // Arbitration after reset: req0, req1, req0.
        drive_pt();
        rst_n = 1'b0;
        @(negedge clk);
        drive_pt();
        rst_n = 1'b1;
        drive_pt();
        req0_rw = 1'b0; req0_dev = 7'h10; req0_reg = 8'h01; req0_wdata = 8'h11; req0_valid = 1'b1;
        req1_rw = 1'b0; req1_dev = 7'h20; req1_reg = 8'h02; req1_wdata = 8'h22; req1_valid = 1'b1;
        @(negedge clk);
        chk("arb1_req0_ready", req0_ready === 1'b1);
        chk("arb1_req1_ready", req1_ready === 1'b0);
        drive_pt();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("arb1_ready_drop", {req0_ready, req1_ready} === 2'b00);
        wait_rsp(1, n);
        chk("arb1_rsp_id", rsp_id === 1'b0);
        drive_pt();
        req0_valid = 1'b1;
        @(negedge clk);
        chk("arb2_req1_ready", req1_ready === 1'b1);
        chk("arb2_req0_ready", req0_ready === 1'b0);
        drive_pt();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("arb2_ready_drop", req1_ready === 1'b0);
        wait_rsp(1, n);
        chk("arb2_rsp_id", rsp_id === 1'b1);
        drive_pt();
        @(negedge clk);
        chk("arb3_req0_ready", req0_ready === 1'b1);
        drive_pt();
        req0_valid = 1'b0;
        @(negedge clk);
        wait_rsp(1, n);
        chk("arb3_rsp_id", rsp_id === 1'b0);

        // Address byte NACKed on a read: straight to STOP, no data returned.
        rd_val  = 8'hC3;
        base    = log_n;
        nack_at = log_n + 1;
        send(1'b1, 1'b1, 7'h50, 8'h10, 8'h00);
        wait_rsp(1, n);
        chk("nack_latency", n === 7);
        chk("nack_flag", rsp_nack === 1'b1);
        chk("nack_rdata", rsp_rdata === 8'h00);
        chk("nack_id", rsp_id === 1'b1);
        chk("nack_timeout", rsp_timeout === 1'b0);
        chk_log(base, 3, {3'd3, 3'd1, 3'd0}, {8'h00, 8'hA0, 8'h00});
        nack_at = -1;

`ifdef FMC_I2C_TIMEOUT_EN
        // Engine withholds done after the register byte; watchdog aborts.
        base    = log_n;
        hold_at = log_n + 2;
        send(1'b0, 1'b0, 7'h21, 8'h77, 8'h99);
        repeat (4) @(negedge clk);
        chk("to_reg_byte", {cmd_valid, cmd_wdata} === 9'h177);
        wait_rsp(0, n);
        chk("to_latency", n === 17);
        chk("to_flag", rsp_timeout === 1'b1);
        chk("to_nack", rsp_nack === 1'b0);
        chk("to_rdata", rsp_rdata === 8'h00);
        hold_at = -1;
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) extra++;
        end
        chk("to_late_done", extra === 0);
        chk_log(base, 3, {3'd1, 3'd1, 3'd0}, {8'h77, 8'h42, 8'h00});
`else
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) extra++;
        end
        chk("idle_no_rsp", extra === 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/fmc_i2c_txn_sequencer.md
# fmc_i2c_txn_sequencer

Register-level I2C transaction sequencer for the FMC424 control path. Accepts single-register write/read requests from two requesters, arbitrates round-robin, and expands each granted request into the byte-command sequence (START, address, register, data, repeated START, STOP) for the downstream byte-level I2C engine. Sits between firmware-side requesters (CPLD control, SI5338B/QSFP management) and the SCL/SDA bit engine.

## Interface
- TIMEOUT_CYCLES, 100000: maximum CLK cycles to wait for `done_valid` after a command handshake.
- CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  request N pending (N = 0, 1).
- reqN_ready  out  1  request N accepted this cycle.
- reqN_rw  in  1  0 = write, 1 = read.
- reqN_dev  in  7  7-bit slave address.
- reqN_reg  in  8  register address.
- reqN_wdata  in  8  write data; ignored for reads.
- cmd_valid  out  1  byte command offered to engine.
- cmd_ready  in  1  engine accepts command.
- cmd_op  out  3  0 START, 1 WRITE, 2 READ_NACK, 3 STOP, 4 RSTART.
- cmd_wdata  out  8  byte for WRITE; 0 otherwise.
- done_valid  in  1  engine finished the last accepted command (1-cycle pulse).
- done_nack  in  1  slave NACKed the WRITE byte; valid with `done_valid`.
- done_rdata  in  8  byte read; valid with `done_valid` after READ_NACK.
- rsp_valid  out  1  one-cycle completion pulse, no backpressure.
- rsp_id  out  1  requester index of the completed transaction.
- rsp_rdata  out  8  read data; 0 for writes or on error.
- rsp_nack  out  1  transaction aborted on NACK.
- rsp_timeout  out  1  transaction aborted on timeout.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. ISSUE/WAIT step a sequence index through the command list.
- Write list: START, WRITE {dev,0}, WRITE reg, WRITE wdata, STOP.
- Read list: START, WRITE {dev,0}, WRITE reg, RSTART, WRITE {dev,1}, READ_NACK, STOP.
- IDLE: `reqN_ready` = (state==IDLE) & grant==N, combinational. The grant goes to the only valid requester; if both are valid, it goes to the one not granted last. After reset, req0 has priority. On valid&ready, latch rw/dev/reg/wdata/id, update the last-grant pointer, and go to ISSUE.
- ISSUE: `cmd_valid`=1 with op/wdata from the sequence index. Op and wdata stay stable until `cmd_ready`. On handshake, go to WAIT.
- WAIT: on `done_valid`, capture `done_rdata` if op was READ_NACK.
  - If a WRITE returned `done_nack`, set the nack flag and jump the index to STOP.
  - If the finished op was STOP, go to RESP; otherwise advance the index and go to ISSUE.
  - `done_nack` on non-WRITE ops is ignored. `done_valid` outside WAIT is ignored.
- RESP: `rsp_valid`=1 for one cycle with latched id/rdata/flags, then IDLE. `rsp_rdata` is forced to 0 when nack or timeout is set.
- Requests arriving while busy wait; they are never dropped. Requesters hold the payload stable while valid.

## Timing
- Reset: state IDLE, last-grant = req1. All outputs are 0 (`reqN_ready` also 0 during reset).
- Accept at cycle T gives `cmd_valid` with START at T+1.
- `cmd_ready` and `done_valid` in the same cycle: the handshake counts; that `done_valid` is ignored, since it belongs to the previous command or is spurious.
- `done_valid` at cycle T in WAIT gives the next `cmd_valid` at T+1.
- STOP done at T gives `rsp_valid` at T+1 and IDLE at T+2. The next grant can happen at T+2.
- Minimum write transaction, with engine ready and done in 1 cycle: 1 accept + 5×(ISSUE+WAIT) + RESP = 12 cycles.
- RST_N assertion mid-transaction: immediate return to IDLE, `cmd_valid` drops asynchronously, no STOP is issued, no response is sent. The bus engine is responsible for its own recovery.

## Configuration
- `FMC_I2C_TIMEOUT_EN` defined: a watchdog counter of width $clog2(TIMEOUT_CYCLES+1) clears on each command handshake and counts in WAIT. Reaching TIMEOUT_CYCLES sets the timeout flag and goes straight to RESP with no STOP. A later stray `done_valid` is ignored.
- Not defined: no counter; WAIT waits indefinitely; `rsp_timeout` is tied to 0; TIMEOUT_CYCLES is unused.

## Test plan
- Req0 write dev 0x3E, reg 0x00, data 0x01, engine always ready with 1-cycle done → cmd_wdata sequence START, 0x7C, 0x00, 0x01, STOP. Then `rsp_valid` with id 0, nack 0, rdata 0.
- Req1 read dev 0x70, reg 0x2D, engine returns rdata 0xA5 → ops START, WRITE 0xE0, WRITE 0x2D, RSTART, WRITE 0xE1, READ_NACK, STOP. Then rsp id 1, rdata 0xA5.
- Both valid at the same cycle after reset, then both re-asserted → grant order req0, req1, req0. Each `reqN_ready` is a single-cycle assertion.
- Engine NACKs the address byte → next op is STOP. Response has nack=1, rdata=0. No register or data byte is issued.
- With `FMC_I2C_TIMEOUT_EN` and TIMEOUT_CYCLES=16, the engine withholds done after the register byte → `rsp_timeout`=1 exactly 16 cycles after that handshake. A late done pulse causes no extra response.
- RST_N pulsed low during WAIT of a read → all outputs 0. After release, a new req0 write starts cleanly with START.
